// File: rtl/irq_controller_pkg.sv
// Shared constants for the interrupt controller: register offsets, FSM state
// encoding, source indices and the bus address decoder.
package irq_controller_pkg;

    localparam logic [31:0] OFF_PEND  = 32'h0;
    localparam logic [31:0] OFF_MASK  = 32'h4;
    localparam logic [31:0] OFF_CAUSE = 32'h8;
    localparam logic [31:0] OFF_CTRL  = 32'hC;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REQ     = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    localparam int SRC_TIMER   = 0;
    localparam int SRC_UART_RX = 1;
    localparam int SRC_UART_TX = 2;
    localparam int SRC_SWITCH  = 3;

    localparam int CAUSE_VALID_BIT = 31;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_PEND,
        SEL_MASK,
        SEL_CAUSE,
        SEL_CTRL
    } reg_sel_e;

    // Width of a source id; a single source still needs one bit.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Exact byte-address match against the four register words.
    function automatic reg_sel_e decode_addr(input logic [31:0] addr, input logic [31:0] base);
        if (addr == base + OFF_PEND)  return SEL_PEND;
        if (addr == base + OFF_MASK)  return SEL_MASK;
        if (addr == base + OFF_CAUSE) return SEL_CAUSE;
        if (addr == base + OFF_CTRL)  return SEL_CTRL;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CPU data-bus port of the interrupt controller.
interface irq_controller_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, output wr, output addr, output wdata, input rdata);
    modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/irq_controller_prio_enc.sv
// Fixed-priority encoder: the lowest set request index wins.
module irq_prio_enc #(
    parameter int NSRC = 4,
    parameter int IDW  = 2
) (
    input  logic [NSRC-1:0] req,
    output logic [IDW-1:0]  id,
    output logic            any
);

    // Scan from the top down so the lowest set index overwrites last.
    always_comb begin
        id  = '0;
        any = 1'b0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                id  = IDW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: pending/mask/cause/ctrl registers plus the request
// handshake with the CPU control unit.
//
//   state      | meaning
//   -----------+-----------------------------------------------------
//   ST_IDLE    | no request outstanding; waits for active and !kernel
//   ST_REQ     | irqout high; waits for irq_taken (or active to drop)
//   ST_SERVICE | handler running; CAUSE valid; waits for eret
module irq_controller
    import irq_controller_pkg::*;
#(
    parameter int          NSRC = 4,
    parameter logic [31:0] BASE = 32'h4000_0030
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NSRC-1:0]  src_pulse,
    irq_controller_if.slave  bus,
    input  logic             kernel,
    input  logic             irq_taken,
    input  logic             eret,
    output logic             irqout
);

    localparam int IDW = id_width(NSRC);

    logic [NSRC-1:0] pend;
    logic [NSRC-1:0] mask;
    logic            ctrl_en;
    logic            cause_valid;
    logic [IDW-1:0]  cause_id;
    logic [1:0]      state;

    reg_sel_e        sel;
    logic            wr_pend;
    logic            wr_mask;
    logic            wr_ctrl;
    logic [NSRC-1:0] active;
    logic [IDW-1:0]  win_id;
    logic            active_any;
    logic [31:0]     rdata_c;
    logic            unused_wdata;

    assign sel     = decode_addr(bus.addr, BASE);
    assign wr_pend = bus.wr && (sel == SEL_PEND);
    assign wr_mask = bus.wr && (sel == SEL_MASK);
    assign wr_ctrl = bus.wr && (sel == SEL_CTRL);

    assign unused_wdata = ^bus.wdata[31:NSRC];

    assign active = pend & mask & {NSRC{ctrl_en}};

    irq_prio_enc #(.NSRC(NSRC), .IDW(IDW)) u_prio_enc (
        .req (active),
        .id  (win_id),
        .any (active_any)
    );

    // Pending bits: W1C from software, a same-cycle event pulse wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~(wr_pend ? bus.wdata[NSRC-1:0] : '0)) | src_pulse;
        end
    end

    // Software-owned enable registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask    <= '0;
            ctrl_en <= 1'b0;
        end else begin
            if (wr_mask) mask    <= bus.wdata[NSRC-1:0];
            if (wr_ctrl) ctrl_en <= bus.wdata[0];
        end
    end

    // Request handshake FSM; CAUSE is captured when the CPU takes the request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cause_valid <= 1'b0;
            cause_id    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (active_any && !kernel) state <= ST_REQ;
                end
                ST_REQ: begin
                    if (irq_taken) begin
                        state       <= ST_SERVICE;
                        cause_valid <= 1'b1;
                        cause_id    <= win_id;
                    end else if (!active_any) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SERVICE: begin
                    if (eret) begin
                        state       <= ST_IDLE;
                        cause_valid <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Decoded straight from the state register, so it never glitches on inputs.
    assign irqout = (state == ST_REQ);

    // Combinational read mux; unused bits read as zero.
    always_comb begin
        rdata_c = '0;
        if (bus.rd) begin
            case (sel)
                SEL_PEND:  rdata_c[NSRC-1:0] = pend;
                SEL_MASK:  rdata_c[NSRC-1:0] = mask;
                SEL_CAUSE: begin
                    rdata_c[CAUSE_VALID_BIT] = cause_valid;
                    rdata_c[IDW-1:0]         = cause_id;
                end
                SEL_CTRL:  rdata_c[0] = ctrl_en;
                default:   rdata_c = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios followed by random traffic,
// checked against a cycle-level reference model through scoreboard queues.
module tb_irq_controller;
    import irq_controller_pkg::*;

    localparam int          NSRC = 4;
    localparam logic [31:0] BASE = 32'h4000_0030;
    localparam logic [31:0] A_PEND  = BASE + OFF_PEND;
    localparam logic [31:0] A_MASK  = BASE + OFF_MASK;
    localparam logic [31:0] A_CAUSE = BASE + OFF_CAUSE;
    localparam logic [31:0] A_CTRL  = BASE + OFF_CTRL;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] src_pulse;
    logic            kernel;
    logic            irq_taken;
    logic            eret;
    logic            irqout;

    irq_controller_if bus();

    irq_controller #(.NSRC(NSRC), .BASE(BASE)) dut (
        .clk       (clk),
        .reset     (reset),
        .src_pulse (src_pulse),
        .bus       (bus),
        .kernel    (kernel),
        .irq_taken (irq_taken),
        .eret      (eret),
        .irqout    (irqout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        q_irq[$];
    logic [31:0] q_rd[$];

    // Reference model: phase 0 = quiet, 1 = requesting, 2 = in handler.
    logic [3:0] m_pend;
    logic [3:0] m_mask;
    logic       m_en;
    int         m_phase;
    logic       m_cv;
    int         m_cid;

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (a == A_PEND)  return {28'h0, m_pend};
        if (a == A_MASK)  return {28'h0, m_mask};
        if (a == A_CAUSE) return {m_cv, 31'(m_cid)};
        if (a == A_CTRL)  return {31'h0, m_en};
        return 32'h0;
    endfunction

    task automatic model_step(input logic [3:0] sp, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic k, input logic tk,
                              input logic er, input logic rs);
        logic [3:0] act;
        int         win;
        if (rs) begin
            m_pend = 0; m_mask = 0; m_en = 0; m_phase = 0; m_cv = 0; m_cid = 0;
            return;
        end
        act = m_pend & m_mask & {4{m_en}};
        win = -1;
        for (int i = 0; i < 4; i++) if (act[i] && win < 0) win = i;
        if (m_phase == 0) begin
            if (win >= 0 && !k) m_phase = 1;
        end else if (m_phase == 1) begin
            if (tk) begin
                m_phase = 2; m_cv = 1; m_cid = (win < 0) ? 0 : win;
            end else if (win < 0) begin
                m_phase = 0;
            end
        end else begin
            if (er) begin m_phase = 0; m_cv = 0; end
        end
        if (w && a == A_PEND) m_pend = m_pend & ~wd[3:0];
        m_pend = m_pend | sp;
        if (w && a == A_MASK) m_mask = wd[3:0];
        if (w && a == A_CTRL) m_en = wd[0];
    endtask

    // One bus cycle: drive, queue expectations for this cycle, advance model.
    task automatic step(input logic [3:0] sp, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd, input logic k,
                        input logic tk, input logic er, input logic rs,
                        input logic use_const, input logic [31:0] const_rd);
        src_pulse = sp; bus.rd = r; bus.wr = w; bus.addr = a; bus.wdata = wd;
        kernel = k; irq_taken = tk; eret = er; reset = rs;
        q_irq.push_back(m_phase == 1);
        if (r) q_rd.push_back(use_const ? const_rd : model_read(a));
        model_step(sp, w, a, wd, k, tk, er, rs);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
        step(4'h0, 0, 1, a, d, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic rd_const(input logic [31:0] a, input logic [31:0] exp_v);
        step(4'h0, 1, 0, a, 32'h0, 0, 0, 0, 0, 1, exp_v);
    endtask

    task automatic pulse(input logic [3:0] sp);
        step(sp, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic take();
        step(4'h0, 0, 0, 32'h0, 32'h0, 0, 1, 0, 0, 0, 32'h0);
    endtask

    task automatic ret();
        step(4'h0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 32'h0);
    endtask

    task automatic do_reset();
        step(4'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 32'h0);
    endtask

    logic        mon_e;
    logic [31:0] mon_rd;

    // Monitor: mid-cycle, compare irqout every cycle and rdata on every read.
    always @(negedge clk) begin
        if (q_irq.size() > 0) begin
            mon_e = q_irq.pop_front();
            checks++;
            if (irqout !== mon_e) begin
                errors++;
                $display("FAIL irqout t=%0t got %b want %b", $time, irqout, mon_e);
            end
        end
        if (bus.rd === 1'b1) begin
            checks++;
            if (q_rd.size() == 0) begin
                errors++;
                $display("FAIL rdata t=%0t got %h want <no expectation queued>", $time, bus.rdata);
            end else begin
                mon_rd = q_rd.pop_front();
                if (bus.rdata !== mon_rd) begin
                    errors++;
                    $display("FAIL rdata t=%0t addr %h got %h want %h", $time, bus.addr, bus.rdata, mon_rd);
                end
            end
        end
    end

    logic [31:0] addr_pool[6];
    logic [3:0]  r_sp;
    logic [31:0] r_wd;

    initial begin
        reset = 1'b1; src_pulse = '0; kernel = 1'b0; irq_taken = 1'b0; eret = 1'b0;
        bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
        m_pend = 0; m_mask = 0; m_en = 0; m_phase = 0; m_cv = 0; m_cid = 0;
        @(posedge clk); #1;

        // Reset state
        do_reset();
        rd_const(A_PEND, 32'h0);
        rd_const(A_MASK, 32'h0);
        rd_const(A_CAUSE, 32'h0);
        rd_const(A_CTRL, 32'h0);

        // Single source, latency and cause capture
        wr_reg(A_MASK, 32'hF);
        wr_reg(A_CTRL, 32'h1);
        idle(2);
        pulse(4'b1 << SRC_UART_TX);
        rd_const(A_PEND, 32'h4);
        take();
        rd_const(A_CAUSE, 32'h8000_0002);
        ret();
        idle(1);
        wr_reg(A_PEND, 32'h4);
        idle(2);

        // Two sources together, back-to-back after eret
        pulse((4'b1 << SRC_UART_RX) | (4'b1 << SRC_SWITCH));
        idle(1);
        take();
        rd_const(A_CAUSE, 32'h8000_0001);
        wr_reg(A_PEND, 32'h2);
        ret();
        idle(1);
        take();
        rd_const(A_CAUSE, 32'h8000_0003);
        wr_reg(A_PEND, 32'h8);
        ret();
        idle(2);

        // W1C racing a new pulse on the same bit
        step(4'b0001, 0, 1, A_PEND, 32'h1, 0, 0, 0, 0, 0, 32'h0);
        rd_const(A_PEND, 32'h1);
        idle(1);
        wr_reg(A_PEND, 32'h1);
        idle(2);

        // Mask drop while requesting, then kernel mode suppression
        pulse(4'b1 << SRC_TIMER);
        idle(1);
        wr_reg(A_MASK, 32'h0);
        idle(2);
        step(4'h0, 0, 1, A_MASK, 32'hF, 1, 0, 0, 0, 0, 32'h0);
        repeat (4) step(4'h0, 0, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 32'h0);
        idle(2);
        take();

        // Reset while servicing, then a stray eret
        do_reset();
        rd_const(A_PEND, 32'h0);
        rd_const(A_MASK, 32'h0);
        rd_const(A_CAUSE, 32'h0);
        rd_const(A_CTRL, 32'h0);
        ret();
        rd_const(A_CAUSE, 32'h0);
        idle(2);

        // Random traffic
        addr_pool[0] = A_PEND; addr_pool[1] = A_MASK; addr_pool[2] = A_CAUSE;
        addr_pool[3] = A_CTRL; addr_pool[4] = BASE + 32'h10; addr_pool[5] = BASE - 32'h4;
        wr_reg(A_MASK, 32'hF);
        wr_reg(A_CTRL, 32'h1);
        for (int n = 0; n < 3000; n++) begin
            r_sp = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            r_wd = ($urandom_range(0, 1) == 0) ? $urandom() : 32'($urandom_range(0, 15));
            step(r_sp,
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 5) == 0),
                 addr_pool[$urandom_range(0, 5)],
                 r_wd,
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 249) == 0),
                 0, 32'h0);
        end
        idle(2);

        @(negedge clk); #1;
        checks++;
        if (q_irq.size() != 0 || q_rd.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d/%0d entries left want 0/0", q_irq.size(), q_rd.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
